// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package mem_pkg;

    // Access size encodings as presented on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    // Exception codes returned on rsp_exc
    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_ADEL = 2'b01;
    localparam logic [1:0] EXC_ADES = 2'b10;
    localparam logic [1:0] EXC_BUS  = 2'b11;

    // First illegal byte address and default ack timeout
    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_3000;
    localparam int          DEFAULT_TIMEOUT    = 64;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // True when the size is unsupported or the address is not naturally aligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_BAD:  bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-enable pattern for the addressed lanes
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data copied into every lane so memory can pick it up under any enable
    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        rep = wdata;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed lane of a read word and sign/zero extends it to 32 bits.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_fill;
    logic        half_fill;

    // Lane selection and extension; word accesses pass straight through
    always_comb begin
        byte_lane = rdata[8*addr_lo +: 8];
        half_lane = rdata[16*addr_lo[1] +: 16];
        byte_fill = sign_ext & byte_lane[7];
        half_fill = sign_ext & half_lane[15];
        ext_data  = rdata;
        case (size)
            SZ_BYTE: ext_data = {{24{byte_fill}}, byte_lane};
            SZ_HALF: ext_data = {{16{half_fill}}, half_lane};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the byte-enable data-memory bus: checks one load/store at a
// time, runs the memory handshake with a timeout, and returns a one-cycle response.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
    parameter int          TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_exc,
    output logic        busy
);

    // Counter only needs to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Request attributes the load path still needs once the request is gone
    logic [1:0]       lat_addr_lo, lat_addr_lo_nxt;
    logic [1:0]       lat_size, lat_size_nxt;
    logic             lat_signed, lat_signed_nxt;

    logic             mem_en_nxt;
    logic             mem_we_nxt;
    logic [31:0]      mem_addr_nxt;
    logic [3:0]       mem_be_nxt;
    logic [31:0]      mem_wdata_nxt;
    logic             rsp_valid_nxt;
    logic [31:0]      rsp_rdata_nxt;
    logic [1:0]       rsp_exc_nxt;

    logic             req_bad;
    logic [31:0]      load_data;

    // Extension works from the latched address/size, not the live request pins
    load_ext u_load_ext (
        .rdata    (mem_rdata),
        .addr_lo  (lat_addr_lo),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .ext_data (load_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Legality of the request currently presented in IDLE
    always_comb begin
        req_bad = is_misaligned(req_size, req_addr[1:0]) || (req_addr >= ADDR_LIMIT);
    end

    // Next-state and next-output decisions; everything holds unless changed below
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        lat_addr_lo_nxt = lat_addr_lo;
        lat_size_nxt    = lat_size;
        lat_signed_nxt  = lat_signed;
        mem_en_nxt      = mem_en;
        mem_we_nxt      = mem_we;
        mem_addr_nxt    = mem_addr;
        mem_be_nxt      = mem_be;
        mem_wdata_nxt   = mem_wdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_exc_nxt     = rsp_exc;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = 32'h0;
                        rsp_exc_nxt   = req_we ? EXC_ADES : EXC_ADEL;
                        state_nxt     = ST_RESP;
                    end else begin
                        mem_en_nxt      = 1'b1;
                        mem_we_nxt      = req_we;
                        mem_addr_nxt    = {req_addr[31:2], 2'b00};
                        mem_be_nxt      = byte_enables(req_size, req_addr[1:0]);
                        mem_wdata_nxt   = replicate_wdata(req_size, req_wdata);
                        lat_addr_lo_nxt = req_addr[1:0];
                        lat_size_nxt    = req_size;
                        lat_signed_nxt  = req_signed;
                        cnt_nxt         = '0;
                        state_nxt       = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (mem_ack) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = mem_we ? 32'h0 : load_data;
                    rsp_exc_nxt   = EXC_NONE;
                    mem_en_nxt    = 1'b0;
                    mem_we_nxt    = 1'b0;
                    state_nxt     = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = 32'h0;
                    rsp_exc_nxt   = EXC_BUS;
                    mem_en_nxt    = 1'b0;
                    mem_we_nxt    = 1'b0;
                    state_nxt     = ST_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins even mid-transaction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_addr_lo <= 2'b00;
            lat_size    <= 2'b00;
            lat_signed  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_be      <= 4'h0;
            mem_wdata   <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_exc     <= EXC_NONE;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lat_addr_lo <= lat_addr_lo_nxt;
            lat_size    <= lat_size_nxt;
            lat_signed  <= lat_signed_nxt;
            mem_en      <= mem_en_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_be      <= mem_be_nxt;
            mem_wdata   <= mem_wdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_exc     <= rsp_exc_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and random loads/stores checked
// against a byte-level behavioural model of the memory access rules.
module tb_mem_access_unit;

    localparam logic [31:0] LIMIT = 32'h0000_3000;
    localparam int          TMO   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;
    logic        busy;

    int n_checks = 0;
    int n_pass = 0;

    mem_access_unit #(
        .ADDR_LIMIT (LIMIT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_exc    (rsp_exc),
        .busy       (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Issues one request, plays the memory side, and checks everything against the model
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_delay);
        int          nbytes;
        int          ofs;
        int          k;
        logic        illegal;
        logic        got;
        logic        hold_bad;
        logic [1:0]  exp_exc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        logic [63:0] lane;
        logic [63:0] mask;
        int          exp_lat;

        // Reference model: sizes in bytes, lanes by byte offset
        ofs      = int'(addr % 32'd4);
        nbytes   = (size == 2'b11) ? 0 : (1 << size);
        illegal  = (nbytes == 0) || (addr >= LIMIT);
        if (!illegal && (ofs % nbytes) != 0) illegal = 1'b1;
        exp_addr = addr - (addr % 32'd4);
        exp_be   = 4'h0;
        exp_wd   = 32'h0;
        exp_rd   = 32'h0;
        if (nbytes != 0) begin
            exp_be = 4'(((1 << nbytes) - 1) << ofs);
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = 8'(wdata >> (8 * (j % nbytes)));
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            lane = (64'(rdata) >> (8 * ofs)) & mask;
            if (sgn && nbytes < 4 && lane[8*nbytes-1]) lane = lane | ~mask;
            exp_rd = we ? 32'h0 : 32'(lane);
        end
        if (illegal) begin
            exp_exc = we ? 2'b10 : 2'b01;
            exp_rd  = 32'h0;
            exp_lat = 1;
        end else if (ack_delay >= TMO) begin
            exp_exc = 2'b11;
            exp_rd  = 32'h0;
            exp_lat = TMO + 1;
        end else begin
            exp_exc = 2'b00;
            exp_lat = 2 + ack_delay;
        end

        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);

        k = 1;
        got = 1'b0;
        hold_bad = 1'b0;
        while (!got && k <= TMO + 10) begin
            if (k == 1 && !illegal) begin
                checkOutput({tag, "_en"}, 32'(mem_en), 32'd1);
                checkOutput({tag, "_we"}, 32'(mem_we), 32'(we));
                checkOutput({tag, "_addr"}, mem_addr, exp_addr);
                checkOutput({tag, "_be"}, 32'(mem_be), 32'(exp_be));
                if (we) checkOutput({tag, "_wdata"}, mem_wdata, exp_wd);
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                checkOutput({tag, "_lat"}, 32'(k), 32'(exp_lat));
                checkOutput({tag, "_exc"}, 32'(rsp_exc), 32'(exp_exc));
                checkOutput({tag, "_rdata"}, rsp_rdata, exp_rd);
                checkOutput({tag, "_en_off"}, 32'(mem_en), 32'd0);
            end else begin
                if (illegal) begin
                    if (mem_en !== 1'b0) hold_bad = 1'b1;
                end else if (mem_en !== 1'b1 || mem_we !== we || mem_addr !== exp_addr ||
                             mem_be !== exp_be || (we && mem_wdata !== exp_wd)) begin
                    hold_bad = 1'b1;
                end
                mem_ack    = !illegal && (k == 1 + ack_delay);
                mem_rdata  = mem_ack ? rdata : $urandom;
                req_valid  = 1'($urandom % 2);
                req_we     = 1'($urandom % 2);
                req_size   = 2'($urandom % 4);
                req_signed = 1'($urandom % 2);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                @(negedge clk);
                k++;
            end
        end
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        if (!got) checkOutput({tag, "_rsp_seen"}, 32'd0, 32'd1);
        checkOutput({tag, "_hold"}, 32'(hold_bad), 32'd0);

        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_exc_kept"}, 32'(rsp_exc), 32'(exp_exc));
    endtask

    initial begin
        logic        seen;
        logic        r_we;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        int          r_delay;

        repeat (3) @(negedge clk);
        checkOutput("rst_en", 32'(mem_en), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_be", 32'(mem_be), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        checkOutput("rst_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_exc", 32'(rsp_exc), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;

        applyStimulus("sw",     1'b1, 2'b10, 1'b0, 32'h100,  32'hDEADBEEF, 32'h0, 0);
        applyStimulus("sb",     1'b1, 2'b00, 1'b0, 32'h203,  32'h123456A5, 32'h0, 1);
        applyStimulus("sh",     1'b1, 2'b01, 1'b0, 32'h202,  32'hFFFF1234, 32'h0, 2);
        applyStimulus("lb",     1'b0, 2'b00, 1'b1, 32'h101,  32'h0, 32'h8081F27F, 3);
        applyStimulus("lbu",    1'b0, 2'b00, 1'b0, 32'h101,  32'h0, 32'h8081F27F, 3);
        applyStimulus("lh",     1'b0, 2'b01, 1'b1, 32'h102,  32'h0, 32'h8081F27F, 3);
        applyStimulus("lhu",    1'b0, 2'b01, 1'b0, 32'h102,  32'h0, 32'h8081F27F, 3);
        applyStimulus("lw",     1'b0, 2'b10, 1'b1, 32'h2FFC, 32'h0, 32'h8081F27F, 0);
        applyStimulus("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102,  32'h0, 32'h0, 0);
        applyStimulus("sh_mis", 1'b1, 2'b01, 1'b0, 32'h3001, 32'h0, 32'h0, 0);
        applyStimulus("sw_rng", 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h0, 0);
        applyStimulus("sz_bad", 1'b0, 2'b11, 1'b0, 32'h10,   32'h0, 32'h0, 0);
        applyStimulus("tmo",    1'b0, 2'b10, 1'b0, 32'h40,   32'h0, 32'h11223344, TMO + 5);
        applyStimulus("ack_end",1'b0, 2'b10, 1'b0, 32'h40,   32'h0, 32'h55667788, TMO - 1);

        // Reset in the middle of a memory request
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("mid_en_pre", 32'(mem_en), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_en", 32'(mem_en), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        mem_ack = 1'b0;
        checkOutput("mid_no_rsp", 32'(seen), 32'd0);

        // Random traffic, mostly legal, with occasional faults and timeouts
        for (int n = 0; n < 40; n++) begin
            r_we    = 1'($urandom % 2);
            r_size  = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            r_addr  = ($urandom % 6 == 0) ? $urandom_range(32'h3010, 32'h2FF0) : $urandom_range(32'h2FFF, 0);
            r_delay = ($urandom % 20 == 0) ? TMO + 2 : int'($urandom % 5);
            applyStimulus($sformatf("rnd%0d", n), r_we, r_size, 1'($urandom % 2), r_addr,
                          $urandom, $urandom, r_delay);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the byte-enable data-memory interface. It accepts one load or store request at a time from the M stage and checks alignment and address range. For legal requests it drives a word-aligned address, a 4-bit byte enable and lane-replicated write data to memory, then waits for an ack. It returns the sign- or zero-extended load data, or an exception code, on a one-cycle response pulse.

Parameters:
ADDR_LIMIT, 32'h0000_3000, first illegal byte address; legal range is addr < ADDR_LIMIT.
TIMEOUT, 64, maximum cycles in REQ without mem_ack before a bus error is reported (≥2).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low (reset==0 clears state on the next clk edge)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_signed  in  1  load sign-extend (lb/lh); ignored for stores and words
req_addr  in  32  byte address
req_wdata  in  32  store data, value in low lanes
mem_en  out  1  memory request, level, held until ack
mem_we  out  1  write strobe qualified by mem_en
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completion; sampled only in REQ
mem_rdata  in  32  read word, valid with mem_ack
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores and exceptions)
rsp_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; timeout counter is cleared.
  - All registered outputs go to 0: mem_en, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_exc.
  - Applies mid-transaction: mem_en drops at that edge, any later mem_ack is ignored, and no response is produced.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is latched and checked.
  - Exception when any of: req_size==11; half with addr[0]==1; word with addr[1:0]!=0; addr >= ADDR_LIMIT. Then go to RESP with rsp_exc = req_we ? 10 : 01. No mem_en is ever asserted.
  - Otherwise register the mem_* outputs, assert mem_en, clear the counter, and go to REQ.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
  - Loads drive mem_be the same way; mem_we=0.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- REQ:
  - mem_* outputs are held stable.
  - An ack may arrive in the first REQ cycle.
  - On mem_ack: capture the extended mem_rdata (loads), drop mem_en, go to RESP with exc 00.
  - Else increment the counter. If counter == TIMEOUT-1 and no ack, drop mem_en and go to RESP with exc 11, rdata 0.
  - Ack in the same cycle as expiry: ack wins.
- Load extension:
  - Byte lane = rdata[8*addr[1:0] +: 8]; half lane = rdata[16*addr[1] +: 16].
  - req_signed selects sign or zero extension; word loads pass through unchanged.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_exc are valid in the same cycle.
  - Go to IDLE; req_ready=0 in this cycle.
  - rsp_valid returns to 0, and rsp_rdata/rsp_exc hold their last values until the next response.
- Latency (acceptance edge = cycle 0):
  - Legal request: mem_en visible in cycle 1; with ack in cycle 1, rsp_valid in cycle 2.
  - Exception: rsp_valid in cycle 1.
  - Minimum initiation interval is 3 cycles.
- Requests presented while not in IDLE are not accepted; the requester must hold them.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - exception codes EXC_NONE/EXC_ADEL/EXC_ADES/EXC_BUS;
  - FSM state enum;
  - default ADDR_LIMIT.
- One combinational sub-module, load_ext: inputs rdata, addr[1:0], size, signed; output the 32-bit extended value. Instantiated once in the REQ capture path.

Test Plan:
- Store word 0xDEADBEEF at 0x100, ack in first REQ cycle → mem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; rsp_valid in cycle 2, exc 00, rdata 0.
- Store byte 0xA5 at 0x203 → be=1000, wdata=0xA5A5A5A5. Store half 0x1234 at 0x202 → be=1100, wdata=0x12341234.
- Load at 0x101, mem_rdata=0x8081_F27F, ack after 3 cycles → lb gives 0xFFFFFFF2, lbu gives 0x000000F2; lh at 0x102 gives 0xFFFF8081; lhu gives 0x00008081.
- Exceptions:
  - lw at 0x102 → rsp_exc=01 in cycle 1, mem_en never high.
  - sh at 0x3001 → 10.
  - sw at 0x3000 (range) → 10.
  - size 11 load → 01.
- No ack for TIMEOUT=64 cycles → mem_en drops, rsp_exc=11, rdata 0. Repeat with ack on the final cycle → exc 00 with data.
- reset=0 while in REQ → next edge: mem_en=0, busy=0, req_ready=1; a subsequent mem_ack produces no rsp_valid.
